pc_gen: RTL and testbench
=========================

Name: pc_gen

Overview:
- Parametrised next-generation program-counter unit for the RISC-V core.
- Holds the architectural PC and selects the next PC from sequential increment, branch/jump redirect, trap vector or a return-address-stack (RAS) pop.
- Also provides misaligned-target detection and a retired-instruction counter.
- Sits between the decode/branch unit and instruction memory. Drives the fetch address and link value (PC+inc) to the writeback mux.

Parameters:
- XLEN, 32: PC and address width.
- RESET_VECTOR, 32'h0000_0000: PC value loaded on reset.
- C_EXT, 0: 1 enables 2-byte (compressed) increments and 2-byte alignment.
- RAS_DEPTH, 4: return-address-stack entries; must be at least 2 and a power of two.
- CNT_WIDTH, 64: width of the retired-instruction counter.

Ports:
- Clk_Core  in  1  core clock.
- Rst_Core_N  in  1  reset; synchronous, active-low.
- Halt  in  1  hold PC; no retire.
- Inst_Compressed  in  1  current instruction is 16-bit; ignored when C_EXT=0.
- Redirect_Valid  in  1  branch taken / jump.
- Redirect_Target  in  XLEN  branch/jump target.
- Trap_Valid  in  1  take trap.
- Trap_Vector  in  XLEN  trap handler address.
- Ras_Push  in  1  current instruction is a call.
- Ras_Pop  in  1  current instruction is a return; next PC is taken from the RAS.
- Program_Count  out  XLEN  current PC.
- Program_Count_Off  out  XLEN  PC + inc (link value).
- Ras_Empty  out  1  RAS holds no entries.
- Misaligned_Fault  out  1  registered one-cycle pulse.
- Fault_Addr  out  XLEN  last misaligned target.
- Retire_Count  out  CNT_WIDTH  retired-instruction count.

Behaviour:
- Reset (Rst_Core_N=0 at a Clk_Core edge) overrides all other inputs:
  - Program_Count=RESET_VECTOR.
  - Retire_Count=0, RAS count=0, Ras_Empty=1.
  - Misaligned_Fault=0, Fault_Addr=0.
  - Reset asserted mid-operation discards all pending redirect, trap and RAS state on that edge.
- Increment: inc=2 when C_EXT=1 and Inst_Compressed=1; otherwise inc=4.
  - Program_Count_Off = Program_Count + inc, combinational, modulo 2^XLEN.
  - At all-ones the PC wraps to 0 with no flag.
- Alignment: a target is misaligned when bit[1] is set (C_EXT=0) or bit[0] is set (C_EXT=1 or 0).
- Next-PC priority, evaluated each edge:
  1. Trap_Valid: PC <= Trap_Vector with bit[0] (and bit[1] if C_EXT=0) forced to 0. This overrides Halt. No retire; RAS unchanged.
  2. Halt: PC held; no retire; RAS and fault outputs unchanged. Misaligned_Fault returns to 0.
  3. Redirect_Valid with misaligned target: PC held, Misaligned_Fault <= 1 for exactly one cycle, Fault_Addr <= Redirect_Target. No retire; RAS untouched, including push/pop.
  4. Redirect_Valid aligned: PC <= Redirect_Target; retire.
  5. Ras_Pop with RAS non-empty: PC <= RAS top; retire.
  6. Otherwise: PC <= Program_Count_Off; retire. This includes Ras_Pop with the RAS empty (underflow falls through to sequential).
- Misaligned_Fault deasserts on any edge not in case 3.
- Retire: Retire_Count += 1 on each retiring edge, wrapping at 2^CNT_WIDTH.
- RAS (circular buffer, top pointer plus saturating count 0..RAS_DEPTH), updated only on retiring edges:
  - Push only: write Program_Count_Off at top+1; count+1, saturating at RAS_DEPTH. When full, the oldest entry is overwritten.
  - Pop only (non-empty): top-1, count-1.
  - Pop on empty: no change.
  - Push and Pop together (co-routine swap): top entry replaced by Program_Count_Off; count unchanged. If the RAS is empty, this acts as a push.
  - The pop value is read before the write on the same edge.
- Ras_Empty = (count==0), registered state.
- Latency: every PC update takes effect on the edge after its inputs are presented. Outputs are valid from the cycle after reset is released.

Test Plan:
- Reset then 3 free cycles, RESET_VECTOR=0x100 -> PC 0x100, 0x104, 0x108, 0x10C; Retire_Count=3.
- C_EXT=1, Inst_Compressed=1 at PC 0x200 -> next PC 0x202; Program_Count_Off=0x202. With C_EXT=0 the same input gives 0x204.
- Redirect 0x1002 with C_EXT=0 at PC 0x40 -> PC stays 0x40, Misaligned_Fault high for one cycle, Fault_Addr=0x1002, Retire_Count unchanged.
- Redirect to 0x800 with Ras_Push at PC 0x10, then Ras_Pop at 0x800 -> PC 0x800, then 0x14; Ras_Empty = 1,0,1 across the sequence.
- RAS_DEPTH=4, 5 pushes then 5 pops -> the first 4 pops return the last 4 links in LIFO order; the 5th pop falls through to PC+4.
- Halt=1 and Trap_Valid=1 at PC 0x50, Trap_Vector=0x303 -> PC 0x300, no retire. Halt alone for 3 cycles holds PC; reset asserted during Halt -> PC=RESET_VECTOR on the next edge.

Source files
------------

// File: rtl/pc_gen.sv
// Program-counter unit: architectural PC, next-PC selection (trap, redirect, RAS return,
// sequential), misaligned-target detection, return-address stack and retired-instruction counter.
module pc_gen #(
   parameter int unsigned     XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter int unsigned     C_EXT        = 0,
   parameter int unsigned     RAS_DEPTH    = 4,
   parameter int unsigned     CNT_WIDTH    = 64
) (
   input  logic                 Clk_Core,
   input  logic                 Rst_Core_N,
   input  logic                 Halt,
   input  logic                 Inst_Compressed,
   input  logic                 Redirect_Valid,
   input  logic [XLEN-1:0]      Redirect_Target,
   input  logic                 Trap_Valid,
   input  logic [XLEN-1:0]      Trap_Vector,
   input  logic                 Ras_Push,
   input  logic                 Ras_Pop,
   output logic [XLEN-1:0]      Program_Count,
   output logic [XLEN-1:0]      Program_Count_Off,
   output logic                 Ras_Empty,
   output logic                 Misaligned_Fault,
   output logic [XLEN-1:0]      Fault_Addr,
   output logic [CNT_WIDTH-1:0] Retire_Count
);

   localparam int unsigned     PTR_W      = $clog2(RAS_DEPTH);
   localparam logic [PTR_W:0]  CNT_FULL   = (PTR_W+1)'(RAS_DEPTH);
   localparam logic [PTR_W:0]  CNT_ONE    = (PTR_W+1)'(1);
   localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
   localparam logic [XLEN-1:0] ALIGN_MASK = (C_EXT != 0) ? ~XLEN'(1) : ~XLEN'(3);

   logic [XLEN-1:0]      pc_q, pc_d;
   logic [XLEN-1:0]      inc, link, trap_pc, ras_top;
   logic                 fault_q, fault_d;
   logic [XLEN-1:0]      fault_addr_q, fault_addr_d;
   logic [CNT_WIDTH-1:0] retire_q, retire_d;
   logic [PTR_W-1:0]     top_q, top_d, ras_waddr;
   logic [PTR_W:0]       cnt_q, cnt_d;
   logic [XLEN-1:0]      ras_mem [RAS_DEPTH];
   logic                 ras_we, ras_empty, tgt_misaligned, retire;

   assign inc            = ((C_EXT != 0) && Inst_Compressed) ? XLEN'(2) : XLEN'(4);
   assign link           = pc_q + inc;
   assign trap_pc        = Trap_Vector & ALIGN_MASK;
   assign tgt_misaligned = (C_EXT != 0) ? Redirect_Target[0] : |Redirect_Target[1:0];
   assign ras_empty      = (cnt_q == '0);
   assign ras_top        = ras_mem[top_q];

   always_comb begin
      pc_d         = pc_q;
      fault_d      = 1'b0;
      fault_addr_d = fault_addr_q;
      retire       = 1'b0;
      if (Trap_Valid) begin
         pc_d = trap_pc;
      end else if (Halt) begin
         pc_d = pc_q;
      end else if (Redirect_Valid && tgt_misaligned) begin
         fault_d      = 1'b1;
         fault_addr_d = Redirect_Target;
      end else begin
         retire = 1'b1;
         if (Redirect_Valid)
            pc_d = Redirect_Target;
         else if (Ras_Pop && !ras_empty)
            pc_d = ras_top;
         else
            pc_d = link;
      end
      retire_d = retire_q + CNT_WIDTH'(retire);
   end

   // Stack bookkeeping; the pop value above is read from the pre-edge top entry.
   always_comb begin
      top_d     = top_q;
      cnt_d     = cnt_q;
      ras_we    = 1'b0;
      ras_waddr = top_q;
      if (retire) begin
         if (Ras_Push && Ras_Pop && !ras_empty) begin
            ras_we    = 1'b1;
            ras_waddr = top_q;
         end else if (Ras_Push) begin
            ras_we    = 1'b1;
            ras_waddr = top_q + PTR_ONE;
            top_d     = top_q + PTR_ONE;
            if (cnt_q != CNT_FULL)
               cnt_d = cnt_q + CNT_ONE;
         end else if (Ras_Pop && !ras_empty) begin
            top_d = top_q - PTR_ONE;
            cnt_d = cnt_q - CNT_ONE;
         end
      end
   end

   always_ff @(posedge Clk_Core) begin
      if (!Rst_Core_N) begin
         pc_q         <= RESET_VECTOR;
         fault_q      <= 1'b0;
         fault_addr_q <= '0;
         retire_q     <= '0;
         top_q        <= '0;
         cnt_q        <= '0;
      end else begin
         pc_q         <= pc_d;
         fault_q      <= fault_d;
         fault_addr_q <= fault_addr_d;
         retire_q     <= retire_d;
         top_q        <= top_d;
         cnt_q        <= cnt_d;
      end
   end

   always_ff @(posedge Clk_Core) begin
      if (Rst_Core_N && ras_we)
         ras_mem[ras_waddr] <= link;
   end

   assign Program_Count     = pc_q;
   assign Program_Count_Off = link;
   assign Ras_Empty         = ras_empty;
   assign Misaligned_Fault  = fault_q;
   assign Fault_Addr        = fault_addr_q;
   assign Retire_Count      = retire_q;

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: two instances (C_EXT=0 and C_EXT=1) share stimulus; a queue-based
// reference model feeds a scoreboard compared one edge later.
module tb_pc_gen;

   localparam logic [31:0] RV = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0, halt = 1'b0, comp = 1'b0, rv = 1'b0, tv = 1'b0, push = 1'b0, pop = 1'b0;
   logic [31:0] rt = '0, tvec = '0;
   logic [31:0] pc0, off0, fa0, pc1, off1, fa1;
   logic        emp0, flt0, emp1, flt1;
   logic [63:0] rc0, rc1;

   always #5 clk = ~clk;

   pc_gen #(.XLEN(32), .RESET_VECTOR(RV), .C_EXT(0), .RAS_DEPTH(4), .CNT_WIDTH(64)) dut0 (
      .Clk_Core(clk), .Rst_Core_N(rst_n), .Halt(halt), .Inst_Compressed(comp),
      .Redirect_Valid(rv), .Redirect_Target(rt), .Trap_Valid(tv), .Trap_Vector(tvec),
      .Ras_Push(push), .Ras_Pop(pop), .Program_Count(pc0), .Program_Count_Off(off0),
      .Ras_Empty(emp0), .Misaligned_Fault(flt0), .Fault_Addr(fa0), .Retire_Count(rc0));

   pc_gen #(.XLEN(32), .RESET_VECTOR(RV), .C_EXT(1), .RAS_DEPTH(4), .CNT_WIDTH(64)) dut1 (
      .Clk_Core(clk), .Rst_Core_N(rst_n), .Halt(halt), .Inst_Compressed(comp),
      .Redirect_Valid(rv), .Redirect_Target(rt), .Trap_Valid(tv), .Trap_Vector(tvec),
      .Ras_Push(push), .Ras_Pop(pop), .Program_Count(pc1), .Program_Count_Off(off1),
      .Ras_Empty(emp1), .Misaligned_Fault(flt1), .Fault_Addr(fa1), .Retire_Count(rc1));

   typedef struct {
      string       name;
      bit          rst_n, halt, comp, rv;
      logic [31:0] rt;
      bit          tv;
      logic [31:0] tvec;
      bit          push, pop;
   } in_t;

   typedef struct {
      string       name;
      int          c;
      logic [31:0] pc, off, fa;
      logic        emp, flt;
      logic [63:0] rc;
   } exp_t;

   exp_t        sb[$];
   int          n_vec = 0, n_err = 0;

   logic [31:0] m_pc[2], m_fa[2];
   logic [63:0] m_rc[2];
   bit          m_flt[2];
   logic [31:0] m_ras0[$], m_ras1[$];

   function automatic in_t mk(string name, bit r_n, bit h, bit cm, bit v, logic [31:0] t,
                              bit trp, logic [31:0] tve, bit ps, bit pp);
      in_t x;
      x.name = name; x.rst_n = r_n; x.halt = h; x.comp = cm; x.rv = v; x.rt = t;
      x.tv = trp; x.tvec = tve; x.push = ps; x.pop = pp;
      return x;
   endfunction

   function automatic in_t idle(string name);
      return mk(name, 1, 0, 0, 0, 32'h0, 0, 32'h0, 0, 0);
   endfunction

   task automatic model_step(input int c, input in_t v, output exp_t e);
      logic [31:0] q[$];
      logic [31:0] inc, link, nxt;
      bit          cext, mis, empty;
      cext = (c == 1);
      if (c == 0) q = m_ras0; else q = m_ras1;
      if (!v.rst_n) begin
         m_pc[c] = RV; m_rc[c] = 0; m_flt[c] = 0; m_fa[c] = 0;
         q.delete();
      end else begin
         inc   = (cext && v.comp) ? 32'd2 : 32'd4;
         link  = m_pc[c] + inc;
         empty = (q.size() == 0);
         mis   = cext ? v.rt[0] : (v.rt[1] | v.rt[0]);
         if (v.tv) begin
            m_pc[c] = v.tvec & (cext ? 32'hFFFF_FFFE : 32'hFFFF_FFFC);
            m_flt[c] = 0;
         end else if (v.halt) begin
            m_flt[c] = 0;
         end else if (v.rv && mis) begin
            m_flt[c] = 1; m_fa[c] = v.rt;
         end else begin
            m_flt[c] = 0;
            m_rc[c]  = m_rc[c] + 1;
            if (v.rv) nxt = v.rt;
            else if (v.pop && !empty) nxt = q[$];
            else nxt = link;
            if (v.push && v.pop && !empty) q[$] = link;
            else if (v.push) begin
               q.push_back(link);
               if (q.size() > 4) void'(q.pop_front());
            end else if (v.pop && !empty) void'(q.pop_back());
            m_pc[c] = nxt;
         end
      end
      if (c == 0) m_ras0 = q; else m_ras1 = q;
      e.name = v.name; e.c = c; e.pc = m_pc[c];
      e.off  = m_pc[c] + ((cext && v.comp) ? 32'd2 : 32'd4);
      e.emp  = (q.size() == 0); e.flt = m_flt[c]; e.fa = m_fa[c]; e.rc = m_rc[c];
   endtask

   task automatic drive(input in_t v);
      exp_t e;
      @(negedge clk);
      rst_n = v.rst_n; halt = v.halt; comp = v.comp; rv = v.rv; rt = v.rt;
      tv = v.tv; tvec = v.tvec; push = v.push; pop = v.pop;
      for (int c = 0; c < 2; c++) begin
         model_step(c, v, e);
         sb.push_back(e);
      end
   endtask

   task automatic finish_cycle();
      exp_t        e;
      logic [31:0] a_pc, a_off, a_fa;
      logic        a_emp, a_flt;
      logic [63:0] a_rc;
      @(posedge clk);
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         if (e.c == 0) begin
            a_pc = pc0; a_off = off0; a_fa = fa0; a_emp = emp0; a_flt = flt0; a_rc = rc0;
         end else begin
            a_pc = pc1; a_off = off1; a_fa = fa1; a_emp = emp1; a_flt = flt1; a_rc = rc1;
         end
         n_vec++;
         if (a_pc !== e.pc || a_off !== e.off || a_emp !== e.emp || a_flt !== e.flt ||
             a_fa !== e.fa || a_rc !== e.rc) begin
            n_err++;
            $display("FAIL %s dut%0d: pc=%h/%h off=%h/%h empty=%b/%b flt=%b/%b faddr=%h/%h rc=%0d/%0d (got/want)",
                     e.name, e.c, a_pc, e.pc, a_off, e.off, a_emp, e.emp, a_flt, e.flt,
                     a_fa, e.fa, a_rc, e.rc);
         end else begin
            $display("ok   %s dut%0d: pc=%h off=%h empty=%b flt=%b faddr=%h rc=%0d",
                     e.name, e.c, a_pc, a_off, a_emp, a_flt, a_fa, a_rc);
         end
      end
   endtask

   task automatic apply(input in_t v);
      drive(v);
      finish_cycle();
   endtask

   task automatic check_const(input string name, input logic [63:0] act, input logic [63:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h want %h", name, act, req);
      end else begin
         $display("ok   %s: %h", name, act);
      end
   endtask

   in_t         tbl[23];
   logic [31:0] pop_pc[5];

   initial begin
      tbl[0]  = mk("reset",        0, 0, 0, 0, 32'h0,        0, 32'h0,   0, 0);
      tbl[1]  = idle("free1");
      tbl[2]  = idle("free2");
      tbl[3]  = idle("free3");
      tbl[4]  = mk("redir_200",    1, 0, 0, 1, 32'h200,      0, 32'h0,   0, 0);
      tbl[5]  = mk("compressed",   1, 0, 1, 0, 32'h0,        0, 32'h0,   0, 0);
      tbl[6]  = mk("redir_40",     1, 0, 0, 1, 32'h40,       0, 32'h0,   0, 0);
      tbl[7]  = mk("mis_1002",     1, 0, 0, 1, 32'h1002,     0, 32'h0,   0, 0);
      tbl[8]  = idle("after_fault");
      tbl[9]  = mk("redir_10",     1, 0, 0, 1, 32'h10,       0, 32'h0,   0, 0);
      tbl[10] = mk("call_800",     1, 0, 0, 1, 32'h800,      0, 32'h0,   1, 0);
      tbl[11] = mk("ret",          1, 0, 0, 0, 32'h0,        0, 32'h0,   0, 1);
      tbl[12] = mk("redir_50",     1, 0, 0, 1, 32'h50,       0, 32'h0,   0, 0);
      tbl[13] = mk("halt_trap",    1, 1, 0, 0, 32'h0,        1, 32'h303, 0, 0);
      tbl[14] = mk("halt1",        1, 1, 0, 0, 32'h0,        0, 32'h0,   0, 0);
      tbl[15] = mk("halt2",        1, 1, 0, 1, 32'h900,      0, 32'h0,   1, 0);
      tbl[16] = mk("halt3",        1, 1, 0, 0, 32'h0,        0, 32'h0,   0, 0);
      tbl[17] = mk("rst_in_halt",  0, 1, 0, 0, 32'h0,        0, 32'h0,   0, 0);
      tbl[18] = mk("redir_top",    1, 0, 0, 1, 32'hFFFF_FFFC, 0, 32'h0,  0, 0);
      tbl[19] = idle("pc_wrap");
      tbl[20] = mk("pop_empty",    1, 0, 0, 0, 32'h0,        0, 32'h0,   0, 1);
      tbl[21] = mk("mis_bit0",     1, 0, 0, 1, 32'h1,        0, 32'h0,   1, 1);
      tbl[22] = mk("halt_clr_flt", 1, 1, 0, 0, 32'h0,        0, 32'h0,   0, 0);

      for (int i = 0; i < 23; i++) begin
         apply(tbl[i]);
         if (i == 3) begin
            check_const("free3_pc", 64'(pc0), 64'h10C);
            check_const("free3_retire", rc0, 64'd3);
         end
         if (i == 13) begin
            check_const("trap_pc_c0", 64'(pc0), 64'h300);
            check_const("trap_pc_c1", 64'(pc1), 64'h302);
         end
      end

      // Link value for a compressed instruction, sampled before the edge.
      apply(mk("redir_200b", 1, 0, 0, 1, 32'h200, 0, 32'h0, 0, 0));
      drive(mk("comp_off", 1, 0, 1, 0, 32'h0, 0, 32'h0, 0, 0));
      #1;
      check_const("comp_off_c1", 64'(off1), 64'h202);
      check_const("comp_off_c0", 64'(off0), 64'h204);
      finish_cycle();

      // Five calls then five returns on a four-deep stack.
      apply(mk("redir_1000", 1, 0, 0, 1, 32'h1000, 0, 32'h0, 0, 0));
      for (int k = 0; k < 5; k++) apply(mk("push", 1, 0, 0, 0, 32'h0, 0, 32'h0, 1, 0));
      pop_pc = '{32'h1014, 32'h1010, 32'h100C, 32'h1008, 32'h100C};
      for (int k = 0; k < 5; k++) begin
         apply(mk("pop", 1, 0, 0, 0, 32'h0, 0, 32'h0, 0, 1));
         check_const("pop_pc", 64'(pc0), 64'(pop_pc[k]));
      end

      // Co-routine swap: pop returns the old top while the link replaces it.
      apply(mk("redir_2000", 1, 0, 0, 1, 32'h2000, 0, 32'h0, 0, 0));
      apply(mk("swap_push", 1, 0, 0, 0, 32'h0, 0, 32'h0, 1, 0));
      apply(mk("swap", 1, 0, 0, 0, 32'h0, 0, 32'h0, 1, 1));
      check_const("swap_pc", 64'(pc0), 64'h2004);
      apply(mk("swap_ret", 1, 0, 0, 0, 32'h0, 0, 32'h0, 0, 1));
      check_const("swap_ret_pc", 64'(pc0), 64'h2008);

      // Reset discards stacked return addresses.
      apply(mk("push_a", 1, 0, 0, 0, 32'h0, 0, 32'h0, 1, 0));
      apply(mk("push_b", 1, 0, 0, 0, 32'h0, 0, 32'h0, 1, 0));
      apply(mk("rst_mid", 0, 0, 0, 1, 32'h3000, 1, 32'h400, 1, 1));
      apply(mk("pop_after_rst", 1, 0, 0, 0, 32'h0, 0, 32'h0, 0, 1));
      check_const("pop_after_rst_pc", 64'(pc0), 64'h104);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
